// File: rtl/id_issue_ctrl_if.sv
// Decode-stage pipeline handshake: upstream (IF -> ID) and downstream (ID -> EXE).
// The stage itself connects through the slave modport. The environment side connects through the master modport.
interface id_issue_ctrl_if #(
    parameter int PW = 64
);
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          in_allowin;
    logic          out_valid;
    logic          out_allowin;
    logic [PW-1:0] out_data;

    modport master (
        output in_valid, in_data, out_allowin,
        input  in_allowin, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_allowin,
        output in_allowin, out_valid, out_data
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode/issue control: pipeline register, operand bypass selection, and a
// long-latency busy scoreboard gating issue on load-use, RAW and WAW hazards.
module id_issue_ctrl #(
    parameter int AW   = 5,
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int NRD  = 2,
    parameter int NFWD = 3,
    parameter int PW   = 64
) (
    input  logic              clk,
    input  logic              resetn,
    id_issue_ctrl_if.slave    hs,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rs_addr,
    input  logic [NRD-1:0]    rs_used,
    input  logic              iss_we,
    input  logic [AW-1:0]     iss_dest,
    input  logic              iss_long,
    input  logic [NRD*DW-1:0] rf_rdata,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD*AW-1:0] fwd_dest,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic              long_done,
    input  logic [AW-1:0]     long_dest,
    input  logic [DW-1:0]     long_data,
    output logic [NRD*DW-1:0] opnd,
    output logic [NREG-1:0]   busy_vec,
    output logic [31:0]       stall_cnt
);
    logic            valid;
    logic            ready_go;
    logic            fire;
    logic            hazard;
    logic            waw;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   val;
    logic            long_hit;
    logic            found;
    logic            not_ready;
    logic [NREG-1:0] busy_nxt;

    assign ready_go      = !hazard;
    assign hs.in_allowin = !valid || (ready_go && hs.out_allowin);
    assign hs.out_valid  = valid && ready_go && !flush;
    assign fire          = hs.out_valid && hs.out_allowin;

    assign waw = iss_we && (iss_dest != '0) && busy_vec[iss_dest]
                 && !(long_done && (long_dest == iss_dest));

    // Forward scan keeps the first (youngest) match; long-unit result and RF are fallbacks.
    always_comb begin
        hazard    = waw;
        opnd      = '0;
        addr      = '0;
        val       = '0;
        long_hit  = 1'b0;
        found     = 1'b0;
        not_ready = 1'b0;
        for (int unsigned p = 0; p < NRD; p++) begin
            addr      = rs_addr[p*AW +: AW];
            long_hit  = long_done && (long_dest == addr);
            found     = 1'b0;
            not_ready = 1'b0;
            val       = long_hit ? long_data : rf_rdata[p*DW +: DW];
            for (int unsigned i = 0; i < NFWD; i++) begin
                if (!found && fwd_valid[i] && (fwd_dest[i*AW +: AW] == addr)) begin
                    found     = 1'b1;
                    val       = fwd_data[i*DW +: DW];
                    not_ready = !fwd_ready[i];
                end
            end
            if (addr == '0)
                val = '0;
            if (rs_used[p] && (addr != '0) && (not_ready || (busy_vec[addr] && !long_hit)))
                hazard = 1'b1;
            opnd[p*DW +: DW] = val;
        end
    end

    always_comb begin
        busy_nxt = busy_vec;
        if (long_done)
            busy_nxt[long_dest] = 1'b0;
        if (fire && iss_long && iss_we && (iss_dest != '0))
            busy_nxt[iss_dest] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid       <= 1'b0;
            hs.out_data <= '0;
            busy_vec    <= '0;
            stall_cnt   <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (hs.in_allowin)
                valid <= hs.in_valid;
            if (hs.in_valid && hs.in_allowin && !flush)
                hs.out_data <= hs.in_data;
            busy_vec <= busy_nxt;
            if (valid && !ready_go && !flush)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: bypass, load-use, long-op scoreboard, WAW, flush, reset.
module tb_id_issue_ctrl;
    localparam int AW = 5, NREG = 32, DW = 32, NRD = 2, NFWD = 3, PW = 64;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic [NRD*AW-1:0] rs_addr;
    logic [NRD-1:0]    rs_used;
    logic              iss_we;
    logic [AW-1:0]     iss_dest;
    logic              iss_long;
    logic [NRD*DW-1:0] rf_rdata;
    logic [NFWD-1:0]    fwd_valid;
    logic [NFWD*AW-1:0] fwd_dest;
    logic [NFWD-1:0]    fwd_ready;
    logic [NFWD*DW-1:0] fwd_data;
    logic              long_done;
    logic [AW-1:0]     long_dest;
    logic [DW-1:0]     long_data;
    logic [NRD*DW-1:0] opnd;
    logic [NREG-1:0]   busy_vec;
    logic [31:0]       stall_cnt;

    int total = 0;
    int bad   = 0;

    id_issue_ctrl_if #(.PW(PW)) hs ();

    id_issue_ctrl #(.AW(AW), .NREG(NREG), .DW(DW), .NRD(NRD), .NFWD(NFWD), .PW(PW)) dut (
        .clk(clk), .resetn(resetn), .hs(hs), .flush(flush),
        .rs_addr(rs_addr), .rs_used(rs_used),
        .iss_we(iss_we), .iss_dest(iss_dest), .iss_long(iss_long),
        .rf_rdata(rf_rdata),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .long_done(long_done), .long_dest(long_dest), .long_data(long_data),
        .opnd(opnd), .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_fwd();
        fwd_valid = '0; fwd_dest = '0; fwd_ready = '0; fwd_data = '0;
    endtask

    task automatic decode(input logic [AW-1:0] rs1, input logic [AW-1:0] rs0, input logic [1:0] used,
                          input logic we, input logic [AW-1:0] dest, input logic lng);
        rs_addr = {rs1, rs0}; rs_used = used; iss_we = we; iss_dest = dest; iss_long = lng;
    endtask

    // Same-register set and clear would mean WAW failed to block issue.
    always @(negedge clk) begin
        if (resetn && long_done && hs.out_valid && hs.out_allowin && iss_long && iss_we
            && (iss_dest != '0) && (long_dest == iss_dest)) begin
            total++;
            bad++;
            $display("FAIL sb_set_clear observed=collision dest=%0d expected=none", iss_dest);
        end
    end

    initial begin
        resetn = 1'b0; flush = 1'b0;
        hs.in_valid = 1'b0; hs.in_data = '0; hs.out_allowin = 1'b1;
        decode(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
        rf_rdata = '0; clear_fwd();
        long_done = 1'b0; long_dest = '0; long_data = '0;
        step(); step();
        settle();
        chk("rst_out_valid", 64'(hs.out_valid), 64'd0);
        chk("rst_in_allowin", 64'(hs.in_allowin), 64'd1);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_out_data", hs.out_data, 64'd0);
        resetn = 1'b1;

        // add r4 then add r5,r4,r4 with EXE bypass
        step();
        hs.in_valid = 1'b1; hs.in_data = 64'h100;
        step();
        decode(5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 1'b0);
        hs.in_data = 64'h104;
        settle();
        chk("b2b_first_valid", 64'(hs.out_valid), 64'd1);
        chk("b2b_first_data", hs.out_data, 64'h100);
        step();
        hs.in_valid = 1'b0;
        decode(5'd4, 5'd4, 2'b11, 1'b1, 5'd5, 1'b0);
        rf_rdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        fwd_valid = 3'b001; fwd_dest[0*AW +: AW] = 5'd4; fwd_ready = 3'b001;
        fwd_data[0*DW +: DW] = 32'h11;
        settle();
        chk("b2b_second_valid", 64'(hs.out_valid), 64'd1);
        chk("b2b_second_data", hs.out_data, 64'h104);
        chk("b2b_opnd0", 64'(opnd[31:0]), 64'h11);
        chk("b2b_opnd1", 64'(opnd[63:32]), 64'h11);
        chk("b2b_stall", 64'(stall_cnt), 64'd0);
        step();
        clear_fwd();

        // load-use on r7
        hs.in_valid = 1'b1; hs.in_data = 64'h200;
        step();
        hs.in_valid = 1'b0;
        decode(5'd0, 5'd7, 2'b01, 1'b1, 5'd8, 1'b0);
        fwd_valid = 3'b001; fwd_dest[0*AW +: AW] = 5'd7; fwd_ready = 3'b000;
        settle();
        chk("lu_stall_valid", 64'(hs.out_valid), 64'd0);
        chk("lu_stall_allowin", 64'(hs.in_allowin), 64'd0);
        step();
        clear_fwd();
        fwd_valid = 3'b010; fwd_dest[1*AW +: AW] = 5'd7; fwd_ready = 3'b010;
        fwd_data[1*DW +: DW] = 32'hABCD;
        settle();
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        chk("lu_issue_valid", 64'(hs.out_valid), 64'd1);
        chk("lu_opnd0", 64'(opnd[31:0]), 64'hABCD);
        step();
        clear_fwd();

        // div r9, reader of r9 waits for long_done
        hs.in_valid = 1'b1; hs.in_data = 64'h300;
        step();
        decode(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1);
        hs.in_data = 64'h304;
        settle();
        chk("div_issue_valid", 64'(hs.out_valid), 64'd1);
        step();
        hs.in_valid = 1'b0;
        decode(5'd0, 5'd9, 2'b01, 1'b1, 5'd10, 1'b0);
        settle();
        chk("div_busy_set", 64'(busy_vec), 64'h200);
        chk("raw_stall_valid", 64'(hs.out_valid), 64'd0);
        repeat (20) step();
        chk("raw_still_stalled", 64'(hs.out_valid), 64'd0);
        long_done = 1'b1; long_dest = 5'd9; long_data = 32'h5;
        settle();
        chk("raw_issue_valid", 64'(hs.out_valid), 64'd1);
        chk("raw_opnd0", 64'(opnd[31:0]), 64'h5);
        chk("raw_stall_cnt", 64'(stall_cnt), 64'd21);
        step();
        long_done = 1'b0;
        settle();
        chk("raw_busy_clear", 64'(busy_vec), 64'd0);
        chk("raw_stage_empty", 64'(hs.out_valid), 64'd0);

        // WAW on r3
        hs.in_valid = 1'b1; hs.in_data = 64'h400;
        step();
        decode(5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 1'b1);
        hs.in_data = 64'h404;
        step();
        hs.in_valid = 1'b0;
        decode(5'd0, 5'd1, 2'b01, 1'b1, 5'd3, 1'b0);
        rf_rdata = {32'h0, 32'h77};
        settle();
        chk("waw_busy3", 64'(busy_vec), 64'h8);
        chk("waw_stall0", 64'(hs.out_valid), 64'd0);
        step();
        settle();
        chk("waw_stall1", 64'(hs.out_valid), 64'd0);
        step();
        long_done = 1'b1; long_dest = 5'd3; long_data = 32'h99;
        settle();
        chk("waw_issue_valid", 64'(hs.out_valid), 64'd1);
        chk("waw_opnd0", 64'(opnd[31:0]), 64'h77);
        chk("waw_stall_cnt", 64'(stall_cnt), 64'd23);
        step();
        long_done = 1'b0;
        settle();
        chk("waw_busy_clear", 64'(busy_vec), 64'd0);

        // flush while stalled on busy r9
        hs.in_valid = 1'b1; hs.in_data = 64'h500;
        step();
        decode(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1);
        hs.in_data = 64'h504;
        step();
        hs.in_valid = 1'b0;
        decode(5'd0, 5'd9, 2'b01, 1'b0, 5'd0, 1'b0);
        settle();
        chk("fl_pre_stall", 64'(hs.out_valid), 64'd0);
        flush = 1'b1;
        settle();
        chk("fl_during_valid", 64'(hs.out_valid), 64'd0);
        step();
        flush = 1'b0;
        decode(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
        settle();
        chk("fl_busy_kept", 64'(busy_vec), 64'h200);
        chk("fl_killed", 64'(hs.out_valid), 64'd0);
        chk("fl_allowin", 64'(hs.in_allowin), 64'd1);
        chk("fl_stall_cnt", 64'(stall_cnt), 64'd23);
        hs.in_valid = 1'b1; hs.in_data = 64'h600; flush = 1'b1;
        step();
        hs.in_valid = 1'b0; flush = 1'b0;
        settle();
        chk("fl_nocap_valid", 64'(hs.out_valid), 64'd0);
        chk("fl_nocap_data", hs.out_data, 64'h504);
        long_done = 1'b1; long_dest = 5'd9; long_data = 32'h0;
        step();
        long_done = 1'b0;
        settle();
        chk("fl_busy_drain", 64'(busy_vec), 64'd0);

        // multiple bypass matches, and r0 with a dest-0 forward
        hs.in_valid = 1'b1; hs.in_data = 64'h700;
        step();
        hs.in_valid = 1'b0;
        decode(5'd0, 5'd6, 2'b11, 1'b0, 5'd0, 1'b0);
        fwd_valid = 3'b111;
        fwd_dest = {5'd6, 5'd0, 5'd6};
        fwd_ready = 3'b101;
        fwd_data = {32'hC, 32'h55, 32'hA};
        settle();
        chk("mm_valid", 64'(hs.out_valid), 64'd1);
        chk("mm_opnd0", 64'(opnd[31:0]), 64'hA);
        chk("mm_opnd1_r0", 64'(opnd[63:32]), 64'd0);
        step();
        clear_fwd();

        // reset mid-stall
        hs.in_valid = 1'b1; hs.in_data = 64'h800;
        step();
        decode(5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1);
        hs.in_data = 64'h804;
        step();
        hs.in_valid = 1'b0;
        decode(5'd0, 5'd9, 2'b01, 1'b0, 5'd0, 1'b0);
        step();
        settle();
        chk("mr_pre_stall_cnt", 64'(stall_cnt), 64'd24);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        settle();
        chk("mr_out_valid", 64'(hs.out_valid), 64'd0);
        chk("mr_in_allowin", 64'(hs.in_allowin), 64'd1);
        chk("mr_busy", 64'(busy_vec), 64'd0);
        chk("mr_stall", 64'(stall_cnt), 64'd0);
        chk("mr_out_data", hs.out_data, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
